misr_param: RTL

- Parametrised multiple-input signature register (MISR) for the BIST datapath.
- Compacts NIN parallel response bits per cycle into a WIDTH-bit signature using a programmable feedback polynomial.
- Counts compaction cycles, freezes on the programmed cycle count or on bist_end, then compares the signature against a golden value and flags pass/fail.
- Sits between the circuit-under-test outputs and the BIST controller; successor to the fixed 12-bit, 3-input MISR.

---
 rtl/misr_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/misr_param.sv
// ----------------------------------------------------------------------------
// misr_param
//   Parametrised multiple-input signature register for the BIST datapath.
//   Each enabled cycle folds NIN response bits into a WIDTH-bit signature with
//   a programmable feedback polynomial. Compaction continues until NCYC cycles
//   have been performed or bist_end is raised. The block then freezes, compares
//   the signature with golden and reports the result on pass.
//
// Ports
//   CLK       in   1      clock, rising edge
//   RST       in   1      asynchronous active-low reset
//   init      in   1      synchronous reload of SEED, counter clear, back to RUN
//   en        in   1      response-valid qualifier
//   din       in   NIN    circuit-under-test response bits
//   bist_end  in   1      early stop request
//   golden    in   WIDTH  expected signature, sampled on the stop edge
//   sig       out  WIDTH  current signature
//   count     out  CW     compaction cycles performed (saturates at NCYC)
//   done      out  1      high while frozen (HOLD)
//   pass      out  1      compare result, valid while done=1
// ----------------------------------------------------------------------------
module misr_param #(
  parameter int               WIDTH = 12,
  parameter int               NIN   = 3,
  parameter logic [WIDTH-1:0] POLY  = 'h0C1,
  parameter logic [WIDTH-1:0] SEED  = 'hBB7,
  parameter int               NCYC  = 256,
  localparam int              CW    = $clog2(NCYC + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             init,
  input  logic             en,
  input  logic [NIN-1:0]   din,
  input  logic             bist_end,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] sig,
  output logic [CW-1:0]    count,
  output logic             done,
  output logic             pass
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_d;
  logic [CW-1:0]    count_d;
  logic             pass_d;

  logic [WIDTH-1:0] d_ext;
  logic [WIDTH-1:0] sig_step;

  // One compaction step. Shifting right puts 0 into the top stage, so stage i
  // receives sig[i+1] and the top stage receives only feedback and input.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    d_ext            = '0;
    d_ext[NIN-1:0]   = din;
    sig_step         = (sig >> 1) ^ (sig[0] ? POLY : '0) ^ d_ext;
  end

  // Next-state and datapath control. init overrides everything; in RUN an
  // early stop beats a compaction request.
  always_comb begin
    state_d = state_q;
    sig_d   = sig;
    count_d = count;
    pass_d  = pass;

    if (init) begin
      state_d = RUN;
      sig_d   = SEED;
      count_d = '0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bist_end) begin
            // Stop without compacting: compare the signature as it stands.
            state_d = HOLD;
            pass_d  = (sig == golden);
          end else if (en) begin
            sig_d   = sig_step;
            count_d = count + CW'(1);
            if (count == LAST_CNT) begin
              // Final compaction: compare against the freshly computed value.
              state_d = HOLD;
              pass_d  = (sig_step == golden);
            end
          end
        end
        HOLD: begin
          // Frozen until init; all other inputs are ignored.
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: the reset branch is listed in the sensitivity list so it acts
  // immediately, without waiting for a clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RUN;
      sig     <= SEED;
      count   <= '0;
      pass    <= 1'b0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values of the others.
      state_q <= state_d;
      sig     <= sig_d;
      count   <= count_d;
      pass    <= pass_d;
    end
  end

  assign done = (state_q == HOLD);

endmodule
